// File: rtl/tcore_param.sv
// Shared types and defaults for the five-stage core's trap logic.
package tcore_param;

  // Machine-mode exception cause codes (4-bit mcause encoding).
  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGNED = 4'd0,
    EXC_INSTR_FAULT      = 4'd1,
    EXC_ILLEGAL          = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_LOAD_FAULT       = 4'd5,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_STORE_FAULT      = 4'd7,
    EXC_ECALL_U          = 4'd8,
    EXC_ECALL_S          = 4'd9,
    EXC_ECALL_M          = 4'd11
  } exc_type_e;

  // Trap sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_MRET     = 3'd4
  } trap_state_e;

  // Stall cycles tolerated before a trap is committed regardless.
  localparam int DRAIN_MAX_DEFAULT = 64;

endpackage

// File: rtl/trap_prio_sel.sv
// Picks the oldest faulting stage (execute > decode > fetch) and muxes its
// cause, pc and tval.
module trap_prio_sel
  import tcore_param::*;
#(
  parameter int XLEN = 32
) (
  input  logic            fe_exc,
  input  logic            de_exc,
  input  logic            ex_exc,
  input  exc_type_e       fe_cause,
  input  exc_type_e       de_cause,
  input  exc_type_e       ex_cause,
  input  logic [XLEN-1:0] fe_pc,
  input  logic [XLEN-1:0] de_pc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] fe_tval,
  input  logic [XLEN-1:0] de_tval,
  input  logic [XLEN-1:0] ex_tval,
  output logic            sel_valid,
  output exc_type_e       sel_cause,
  output logic [XLEN-1:0] sel_pc,
  output logic [XLEN-1:0] sel_tval
);

  // Oldest-first priority mux; younger stages are on the wrong path.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path
    // leaves one unassigned and infers a latch.
    sel_valid = 1'b0;
    sel_cause = EXC_INSTR_MISALIGNED;
    sel_pc    = '0;
    sel_tval  = '0;
    if (ex_exc) begin
      sel_valid = 1'b1;
      sel_cause = ex_cause;
      sel_pc    = ex_pc;
      sel_tval  = ex_tval;
    end else if (de_exc) begin
      sel_valid = 1'b1;
      sel_cause = de_cause;
      sel_pc    = de_pc;
      sel_tval  = de_tval;
    end else if (fe_exc) begin
      sel_valid = 1'b1;
      sel_cause = fe_cause;
      sel_pc    = fe_pc;
      sel_tval  = fe_tval;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencing controller: captures the oldest exception, waits out
// memory stalls, commits mepc/mcause/mtval, flushes and redirects fetch to
// mtvec. Also sequences mret back to mepc.
module trap_ctrl
  import tcore_param::*;
#(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fe_exc_i,
  input  logic            de_exc_i,
  input  logic            ex_exc_i,
  input  exc_type_e       fe_cause_i,
  input  exc_type_e       de_cause_i,
  input  exc_type_e       ex_cause_i,
  input  logic [XLEN-1:0] fe_pc_i,
  input  logic [XLEN-1:0] de_pc_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] fe_tval_i,
  input  logic [XLEN-1:0] de_tval_i,
  input  logic [XLEN-1:0] ex_tval_i,
  input  logic            mret_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_we_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_active_o,
  output logic            drain_timeout_o
);

  localparam int              CNT_W    = $clog2(DRAIN_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
  // Direct-mode vector base and mepc alignment masks.
  localparam logic [XLEN-1:0] VEC_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_MASK  = ~XLEN'(1);

  trap_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            capture;
  logic            timeout_hit;

  logic            sel_valid;
  exc_type_e       sel_cause;
  logic [XLEN-1:0] sel_pc;
  logic [XLEN-1:0] sel_tval;

  exc_type_e       cap_cause_q;
  logic [XLEN-1:0] cap_pc_q;
  logic [XLEN-1:0] cap_tval_q;

  logic            csr_we_d, redirect_d, busy_d;
  logic [XLEN-1:0] redirect_pc_d;
  logic            csr_we_q, redirect_q, busy_q, timeout_q;
  logic [XLEN-1:0] redirect_pc_q;

  trap_prio_sel #(.XLEN(XLEN)) u_prio (
    .fe_exc    (fe_exc_i),
    .de_exc    (de_exc_i),
    .ex_exc    (ex_exc_i),
    .fe_cause  (fe_cause_i),
    .de_cause  (de_cause_i),
    .ex_cause  (ex_cause_i),
    .fe_pc     (fe_pc_i),
    .de_pc     (de_pc_i),
    .ex_pc     (ex_pc_i),
    .fe_tval   (fe_tval_i),
    .de_tval   (de_tval_i),
    .ex_tval   (ex_tval_i),
    .sel_valid (sel_valid),
    .sel_cause (sel_cause),
    .sel_pc    (sel_pc),
    .sel_tval  (sel_tval)
  );

  // Next-state logic plus the values the output registers take next cycle,
  // so registered outputs line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Exceptions win over a same-cycle mret.
        if (sel_valid) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = stall_i ? ST_DRAIN : ST_COMMIT;
        end else if (mret_i) begin
          state_d = ST_MRET;
        end
      end
      ST_DRAIN: begin
        if (!stall_i) begin
          state_d = ST_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_COMMIT;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      ST_MRET:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    csr_we_d   = (state_d == ST_COMMIT);
    redirect_d = (state_d == ST_REDIRECT) || (state_d == ST_MRET);
    busy_d     = (state_d != ST_IDLE);
    unique case (state_d)
      ST_REDIRECT: redirect_pc_d = mtvec_i & VEC_MASK;
      ST_MRET:     redirect_pc_d = mepc_i;
      default:     redirect_pc_d = '0;
    endcase
  end

  // State, drain counter, registered outputs and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      csr_we_q      <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      csr_we_q      <= csr_we_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  // Captured trap record; holds until the next accepted exception.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: these are a handful of flops, not a memory, so they are reset
      // to keep CSR write data at zero out of reset.
      cap_cause_q <= EXC_INSTR_MISALIGNED;
      cap_pc_q    <= '0;
      cap_tval_q  <= '0;
    end else if (capture) begin
      cap_cause_q <= sel_cause;
      cap_pc_q    <= sel_pc;
      cap_tval_q  <= sel_tval;
    end
  end

  assign csr_we_o        = csr_we_q;
  assign mepc_o          = cap_pc_q & PC_MASK;
  assign mcause_o        = {{(XLEN-4){1'b0}}, cap_cause_q};
  assign mtval_o         = cap_tval_q;
  assign flush_o         = busy_q;
  assign trap_active_o   = busy_q;
  assign redirect_o      = redirect_q;
  assign redirect_pc_o   = redirect_pc_q;
  assign drain_timeout_o = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a vector table for single-trap / mret
// sequences, plus hand sequences for drain, timeout, wrong-path and reset.
module tb_trap_ctrl;
  import tcore_param::*;

  localparam int XLEN = 32;

  logic            clk, rst_n;
  logic            fe_exc, de_exc, ex_exc;
  exc_type_e       fe_cause, de_cause, ex_cause;
  logic [XLEN-1:0] fe_pc, de_pc, ex_pc, fe_tval, de_tval, ex_tval;
  logic            mret, stall;
  logic [XLEN-1:0] mtvec, mepc_in;
  logic            csr_we, flush, redirect, trap_active, drain_timeout;
  logic [XLEN-1:0] mepc, mcause, mtval, redirect_pc;

  int n_vec  = 0;
  int n_fail = 0;

  trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fe_exc_i(fe_exc), .de_exc_i(de_exc), .ex_exc_i(ex_exc),
    .fe_cause_i(fe_cause), .de_cause_i(de_cause), .ex_cause_i(ex_cause),
    .fe_pc_i(fe_pc), .de_pc_i(de_pc), .ex_pc_i(ex_pc),
    .fe_tval_i(fe_tval), .de_tval_i(de_tval), .ex_tval_i(ex_tval),
    .mret_i(mret), .stall_i(stall), .mtvec_i(mtvec), .mepc_i(mepc_in),
    .csr_we_o(csr_we), .mepc_o(mepc), .mcause_o(mcause), .mtval_o(mtval),
    .flush_o(flush), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .trap_active_o(trap_active), .drain_timeout_o(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            fe, de, ex, mr;
    exc_type_e       fc, dc, xc;
    logic [XLEN-1:0] fp, dp, xp, ft, dt, xt;
    logic [XLEN-1:0] tvec, epc;
    logic            exp_trap;
    logic [XLEN-1:0] exp_mepc, exp_mcause, exp_mtval, exp_rpc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fe_exc = 0; de_exc = 0; ex_exc = 0; mret = 0;
    fe_cause = EXC_INSTR_MISALIGNED; de_cause = EXC_INSTR_MISALIGNED;
    ex_cause = EXC_INSTR_MISALIGNED;
    fe_pc = '0; de_pc = '0; ex_pc = '0;
    fe_tval = '0; de_tval = '0; ex_tval = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_csr_we"}, XLEN'(csr_we), '0);
    check({tag, "_mepc"}, mepc, '0);
    check({tag, "_mcause"}, mcause, '0);
    check({tag, "_mtval"}, mtval, '0);
    check({tag, "_flush"}, XLEN'(flush), '0);
    check({tag, "_redirect"}, XLEN'(redirect), '0);
    check({tag, "_redirect_pc"}, redirect_pc, '0);
    check({tag, "_trap_active"}, XLEN'(trap_active), '0);
    check({tag, "_drain_timeout"}, XLEN'(drain_timeout), '0);
  endtask

  task automatic fire_ex(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tv);
    ex_exc = 1; ex_cause = EXC_ILLEGAL; ex_pc = pc; ex_tval = tv;
  endtask

  int pulses;
  int edges;

  initial begin
    // {fe,de,ex,mret, fc,dc,xc, fp,dp,xp, ft,dt,xt, mtvec,mepc, trap, mepc,mcause,mtval,rpc}
    vecs[0] = '{0,0,1,0, EXC_INSTR_MISALIGNED,EXC_INSTR_MISALIGNED,EXC_ILLEGAL,
                0,0,32'h100, 0,0,32'hDEAD, 32'h803,0, 1, 32'h100,2,32'hDEAD,32'h800};
    vecs[1] = '{1,1,1,0, EXC_INSTR_FAULT,EXC_BREAKPOINT,EXC_LOAD_FAULT,
                32'h10,32'h0C,32'h08, 1,2,3, 32'h1000,0, 1, 32'h08,5,3,32'h1000};
    vecs[2] = '{1,0,0,0, EXC_INSTR_MISALIGNED,EXC_ILLEGAL,EXC_ILLEGAL,
                32'h203,0,0, 32'h203,0,0, 32'h2002,0, 1, 32'h202,0,32'h203,32'h2000};
    vecs[3] = '{1,1,0,0, EXC_INSTR_FAULT,EXC_ECALL_M,EXC_ILLEGAL,
                32'h48,32'h44,0, 32'h9,0,0, 32'hFFFF_FFFF,0, 1, 32'h44,11,0,32'hFFFF_FFFC};
    vecs[4] = '{0,0,0,1, EXC_INSTR_MISALIGNED,EXC_INSTR_MISALIGNED,EXC_INSTR_MISALIGNED,
                0,0,0, 0,0,0, 32'h400,32'h2000, 0, 0,0,0,32'h2000};
    vecs[5] = '{0,1,0,1, EXC_INSTR_MISALIGNED,EXC_STORE_FAULT,EXC_INSTR_MISALIGNED,
                0,32'h300,0, 0,32'hBEEF,0, 32'h400,32'h2000, 1, 32'h300,7,32'hBEEF,32'h400};
    vecs[6] = '{0,1,1,0, EXC_INSTR_MISALIGNED,EXC_ILLEGAL,EXC_ECALL_U,
                0,32'h50,32'h8000_0000, 0,32'h1,32'hFFFF_FFFF, 32'h0,0, 1,
                32'h8000_0000,8,32'hFFFF_FFFF,32'h0};

    clear_inputs();
    stall = 0; mtvec = '0; mepc_in = '0;
    rst_n = 0;
    #1;
    check_all_zero("reset");
    step(); step();
    rst_n = 1;
    step();
    check("idle_active", XLEN'(trap_active), '0);

    // Table-driven single trap / mret sequences.
    for (int i = 0; i < 7; i++) begin
      fe_exc = vecs[i].fe; de_exc = vecs[i].de; ex_exc = vecs[i].ex; mret = vecs[i].mr;
      fe_cause = vecs[i].fc; de_cause = vecs[i].dc; ex_cause = vecs[i].xc;
      fe_pc = vecs[i].fp; de_pc = vecs[i].dp; ex_pc = vecs[i].xp;
      fe_tval = vecs[i].ft; de_tval = vecs[i].dt; ex_tval = vecs[i].xt;
      mtvec = vecs[i].tvec; mepc_in = vecs[i].epc;
      step();
      clear_inputs();
      if (vecs[i].exp_trap) begin
        check($sformatf("v%0d_commit_we", i), XLEN'(csr_we), 1);
        check($sformatf("v%0d_commit_redir", i), XLEN'(redirect), 0);
        check($sformatf("v%0d_commit_flush", i), XLEN'(flush), 1);
        check($sformatf("v%0d_mepc", i), mepc, vecs[i].exp_mepc);
        check($sformatf("v%0d_mcause", i), mcause, vecs[i].exp_mcause);
        check($sformatf("v%0d_mtval", i), mtval, vecs[i].exp_mtval);
        step();
        check($sformatf("v%0d_redir_we", i), XLEN'(csr_we), 0);
      end else begin
        check($sformatf("v%0d_mret_we", i), XLEN'(csr_we), 0);
      end
      check($sformatf("v%0d_redirect", i), XLEN'(redirect), 1);
      check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
      check($sformatf("v%0d_redir_flush", i), XLEN'(flush), 1);
      step();
      check($sformatf("v%0d_idle_active", i), XLEN'(trap_active), 0);
      check($sformatf("v%0d_idle_redirect", i), XLEN'(redirect), 0);
      check($sformatf("v%0d_idle_flush", i), XLEN'(flush), 0);
    end

    // Trap with 3 stall cycles: DRAIN for N+1..N+3, COMMIT at N+4.
    mtvec = 32'h600;
    fire_ex(32'h124, 32'h77);
    stall = 1;
    for (int c = 1; c <= 3; c++) begin
      step();
      clear_inputs();
      if (c == 3) stall = 0;
      check($sformatf("drain%0d_flush", c), XLEN'(flush), 1);
      check($sformatf("drain%0d_we", c), XLEN'(csr_we), 0);
      check($sformatf("drain%0d_active", c), XLEN'(trap_active), 1);
    end
    step();
    check("drain_commit_we", XLEN'(csr_we), 1);
    check("drain_commit_mepc", mepc, 32'h124);
    check("drain_no_timeout", XLEN'(drain_timeout), 0);
    step();
    check("drain_redirect_pc", redirect_pc, 32'h600);
    step();
    check("drain_idle", XLEN'(trap_active), 0);

    // New exception during COMMIT is wrong-path: exactly one csr_we pulse.
    fire_ex(32'h700, 32'h1);
    step();
    pulses = csr_we ? 1 : 0;
    fire_ex(32'h900, 32'h2);
    step();
    clear_inputs();
    if (csr_we) pulses++;
    for (int c = 0; c < 3; c++) begin
      step();
      if (csr_we) pulses++;
    end
    check("commit_ignore_pulses", XLEN'(pulses), 1);
    check("commit_ignore_mepc", mepc, 32'h700);
    check("commit_ignore_idle", XLEN'(trap_active), 0);

    // Stall held past DRAIN_MAX: forced commit after 65 edges, sticky flag.
    fire_ex(32'h440, 32'h3);
    stall = 1;
    edges = 0;
    do begin
      step();
      clear_inputs();
      edges++;
    end while (!csr_we && edges < 200);
    check("timeout_edges", XLEN'(edges), 65);
    check("timeout_flag", XLEN'(drain_timeout), 1);
    check("timeout_mepc", mepc, 32'h440);
    stall = 0;
    step(); step(); step();
    check("timeout_sticky", XLEN'(drain_timeout), 1);
    check("timeout_idle", XLEN'(trap_active), 0);

    // Reset asserted in COMMIT aborts the trap with no later pulses.
    fire_ex(32'h888, 32'h5);
    step();
    clear_inputs();
    check("rst_pre_we", XLEN'(csr_we), 1);
    #2 rst_n = 0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (csr_we || redirect || trap_active) pulses++;
    end
    check("rst_no_pulse", XLEN'(pulses), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencing controller for the five-stage core. It takes per-stage exception flags with their cause, PC and tval, picks the oldest faulting instruction and waits out memory stalls. It then commits mepc/mcause/mtval to the CSR file, flushes the pipeline and redirects fetch to mtvec. It also sequences `mret` returns to mepc, and drives the `trap_active_o` flag consumed by writeback and hazard logic.

## Interface
- `XLEN`, 32, datapath width.
- `DRAIN_MAX`, 64, max stall cycles waited before forced commit.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `fe_exc_i` / `de_exc_i` / `ex_exc_i`  in  1 each  exception valid from fetch/decode/execute.
- `fe_cause_i` / `de_cause_i` / `ex_cause_i`  in  `exc_type_e` (4) each  cause code.
- `fe_pc_i` / `de_pc_i` / `ex_pc_i`  in  XLEN each  PC of faulting instruction.
- `fe_tval_i` / `de_tval_i` / `ex_tval_i`  in  XLEN each  trap value.
- `mret_i`  in  1  mret reached execute, not stalled.
- `stall_i`  in  1  pipeline stall (memory busy).
- `mtvec_i`, `mepc_i`  in  XLEN each  current CSR values.
- `csr_we_o`  out  1  one-cycle write strobe for mepc/mcause/mtval.
- `mepc_o`, `mcause_o`, `mtval_o`  out  XLEN each  CSR write data.
- `flush_o`  out  1  kill all stages younger than writeback.
- `redirect_o`  out  1  one-cycle fetch redirect pulse.
- `redirect_pc_o`  out  XLEN  redirect target.
- `trap_active_o`  out  1  high whenever state ≠ IDLE.
- `drain_timeout_o`  out  1  sticky: drain hit DRAIN_MAX.

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT, MRET.
- Priority: ex > de > fe (oldest first); at most one trap captured.
- IDLE, any exc valid: latch winner's cause/pc/tval. If `stall_i` = 0, go to COMMIT; otherwise go to DRAIN.
- IDLE, no exc, `mret_i` = 1: go to MRET. An exception in the same cycle wins and `mret_i` is dropped.
- DRAIN: counter increments each stalled cycle. Go to COMMIT on `stall_i` = 0 or counter = DRAIN_MAX-1. The latter sets `drain_timeout_o`, which clears only on reset.
- COMMIT: `csr_we_o` = 1; `mepc_o` = pc with bit0 cleared; `mcause_o` = zero-extended cause, bit XLEN-1 = 0; `mtval_o` = tval. Next state REDIRECT.
- REDIRECT: `redirect_o` = 1; `redirect_pc_o` = {mtvec_i[XLEN-1:2], 2'b00}, direct mode only. Next state IDLE.
- MRET: `redirect_o` = 1, `redirect_pc_o` = mepc_i. Next state IDLE.
- `flush_o` = 1 in DRAIN, COMMIT, REDIRECT, MRET.
- Exc/mret inputs are ignored in any non-IDLE state (wrong-path).
- Outputs are registered. Captured registers hold until the next capture.

## Timing
- Trap detected at cycle N with no stall: COMMIT at N+1, REDIRECT at N+2, IDLE at N+3. A new trap is accepted at N+3.
- With k stall cycles: COMMIT at N+1+k.
- `mret` at N: redirect pulse at N+1, IDLE at N+2.
- Reset: every output is 0, state = IDLE, counter = 0, latches = 0. Reset mid-sequence aborts with no `csr_we_o`/`redirect_o` pulse after release.
- `csr_we_o` and `redirect_o` are exactly one cycle wide per trap; never asserted together.

## Structure
- `tcore_param` package holds `exc_type_e` (4-bit cause enum), `trap_state_e`, and the default `DRAIN_MAX`.
- One combinational sub-module, `trap_prio_sel`, selects the oldest valid stage and muxes its cause, pc and tval.
- The counter width is $clog2(DRAIN_MAX).

## Test plan
- `ex_exc_i` with cause ILLEGAL (2), pc 0x100, tval 0xDEAD, no stall, mtvec 0x803 -> `csr_we_o` at N+1 with mepc 0x100, mcause 2, mtval 0xDEAD. Redirect to 0x800 at N+2.
- fe, de and ex all valid in the same cycle (pcs 0x10/0x0C/0x08) -> mepc 0x08 with ex cause. Other stages are ignored.
- Trap with `stall_i` high for 3 cycles -> `flush_o` high throughout, COMMIT at N+4, `drain_timeout_o` stays 0. With stall held beyond DRAIN_MAX -> forced commit and `drain_timeout_o` = 1.
- `mret_i` with mepc_i 0x2000 -> redirect to 0x2000 at N+1 and no `csr_we_o`. Simultaneous `mret_i` and `de_exc_i` -> trap path taken.
- New `ex_exc_i` during COMMIT -> ignored, a single `csr_we_o` pulse.
- `rst_ni` asserted in COMMIT -> all outputs 0 immediately, no redirect after release.
